conv_maxpool: RTL and testbench

//  Downstream stage of the convolutor top. Consumes the valid-qualified convolution output stream
//  (MAP_W x MAP_W feature map, raster order, MAP_W = N-K_SIZE+1), applies optional ReLU, then
//  2x2 stride-2 max pooling. Emits one pooled pixel per 2x2 window with a single-cycle valid strobe.

---
 rtl/conv_maxpool_pkg.sv | 24 ++
 rtl/conv_maxpool_line_buf.sv | 23 ++
 rtl/conv_maxpool.sv | 118 +++++++++++
 tb/tb_conv_maxpool.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_maxpool_pkg.sv
// Shared geometry for the convolutor output stage: parameter defaults and
// helpers that derive feature-map and pooled-row sizes.
package conv_maxpool_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_K_SIZE     = 3;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_Q          = 5;
  localparam int DEF_RELU       = 1;

  function automatic int map_w(input int n, input int k_size);
    return n - k_size + 1;
  endfunction

  function automatic int pool_w(input int m);
    return m / 2;
  endfunction

  // Index width that stays legal for a depth of 1.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_maxpool_line_buf.sv
// One pooled-row of partial maxima: single write port and an
// asynchronous read port sharing the window index.
module conv_maxpool_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int AW         = 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_maxpool.sv
// Optional ReLU followed by 2x2 stride-2 max pooling over the raster-order
// convolution stream; one pooled pixel per window, no backpressure.
module conv_maxpool
  import conv_maxpool_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int K_SIZE     = DEF_K_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int Q          = DEF_Q,
  parameter int RELU       = DEF_RELU
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int MAP_W  = map_w(N, K_SIZE);
  localparam int POOL_W = pool_w(MAP_W);
  localparam int CW     = idx_w(MAP_W);
  localparam int JW     = idx_w(POOL_W);
  localparam bit ODD    = (MAP_W % 2) != 0;
  localparam logic [CW-1:0] LAST = CW'(MAP_W - 1);

  if (MAP_W < 2 || Q < 0 || Q >= DATA_WIDTH) begin : g_bad_cfg
    $error("conv_maxpool: MAP_W must be >= 2 and Q within DATA_WIDTH");
  end

  logic [CW-1:0]                r_col, r_row;
  logic signed [DATA_WIDTH-1:0] r_hold, r_data;
  logic                         r_valid, r_done, r_busy;

  logic [CW-1:0]                w_col, w_row;
  logic [JW-1:0]                w_j;
  logic signed [DATA_WIDTH-1:0] w_pix, w_lb_rd, w_max_hp, w_max_all;
  logic                         w_col_ok, w_row_ok, w_latch, w_lb_we, w_emit;

  // A start pulse re-bases the same-cycle pixel to (0,0).
  assign w_col = i_start ? '0 : r_col;
  assign w_row = i_start ? '0 : r_row;
  assign w_j   = JW'(w_col >> 1);

  assign w_pix = ((RELU != 0) && i_data[DATA_WIDTH-1]) ? '0 : i_data;

  // With odd MAP_W the trailing column/row have no partner and are dropped.
  assign w_col_ok = !(ODD && (w_col == LAST));
  assign w_row_ok = !(ODD && (w_row == LAST));

  assign w_latch = !w_col[0] && w_col_ok;
  assign w_lb_we = i_valid && w_col[0] && !w_row[0] && w_row_ok;
  assign w_emit  = w_col[0] && w_row[0] && w_row_ok;

  assign w_max_hp  = (r_hold > w_pix) ? r_hold : w_pix;
  assign w_max_all = (w_lb_rd > w_max_hp) ? w_lb_rd : w_max_hp;

  conv_maxpool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (POOL_W),
    .AW        (JW)
  ) u_line_buf (
    .clk    (clk),
    .i_we   (w_lb_we),
    .i_addr (w_j),
    .i_wdata(w_max_hp),
    .o_rdata(w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (i_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_busy <= 1'b0;
      end
      if (i_valid) begin
        r_busy <= 1'b1;
        if (w_col == LAST) begin
          r_col <= '0;
          if (w_row == LAST) begin
            r_row  <= '0;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_row <= w_row + CW'(1);
          end
        end else begin
          r_col <= w_col + CW'(1);
        end
        if (w_latch) r_hold <= w_pix;
        if (w_emit) begin
          r_data  <= w_max_all;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_conv_maxpool.sv
// Directed bench for conv_maxpool: three instances cover MAP_W=4 with and
// without ReLU, and MAP_W=5, all fed from one shared input stream.
`timescale 1ns/1ps
module tb_conv_maxpool;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;

  logic [15:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_done, b_done, c_done;
  logic        a_busy, b_busy, c_busy;

  always #5 clk = ~clk;

  conv_maxpool #(.N(6), .K_SIZE(3), .DATA_WIDTH(16), .Q(5), .RELU(1)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .o_data(a_data), .o_valid(a_valid), .o_done(a_done), .o_busy(a_busy));

  conv_maxpool #(.N(6), .K_SIZE(3), .DATA_WIDTH(16), .Q(5), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .o_data(b_data), .o_valid(b_valid), .o_done(b_done), .o_busy(b_busy));

  conv_maxpool #(.N(7), .K_SIZE(3), .DATA_WIDTH(16), .Q(5), .RELU(1)) dut_c (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .o_data(c_data), .o_valid(c_valid), .o_done(c_done), .o_busy(c_busy));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] qa_d[$], qb_d[$], qc_d[$];
  int          qa_t[$], qc_t[$], qa_done[$], qc_done[$];
  logic        qa_db[$];

  always @(posedge clk) begin
    #1;
    if (a_valid) begin qa_d.push_back(a_data); qa_t.push_back(cyc); end
    if (a_done)  begin qa_done.push_back(cyc); qa_db.push_back(a_busy); end
    if (b_valid) qb_d.push_back(b_data);
    if (c_valid) begin qc_d.push_back(c_data); qc_t.push_back(cyc); end
    if (c_done)  qc_done.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;
  int acc[64];
  int gtab[16] = '{0, 2, 1, 3, 0, 0, 1, 2, 3, 1, 0, 2, 0, 3, 1, 2};

  task automatic clear_q();
    qa_d.delete(); qb_d.delete(); qc_d.delete();
    qa_t.delete(); qc_t.delete(); qa_done.delete(); qc_done.delete(); qa_db.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic send(input logic [15:0] d, input logic st, input int gap, output int stamp);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    i_data = d; i_valid = 1'b1; i_start = st;
    @(posedge clk);
    #1;
    stamp = cyc;
    i_valid = 1'b0; i_start = 1'b0;
  endtask

  // mode 0: ascending 1..n, mode 1: descending n..1, mode 2: all -3
  task automatic send_frame(input int n, input int mode, input int base, input int use_gaps,
                            input logic st0);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      d = (mode == 0) ? 16'(i + 1) : (mode == 1) ? 16'(n - i) : 16'hFFFD;
      send(d, st0 && (i == 0), (use_gaps != 0) ? gtab[i % 16] : 0, acc[base + i]);
    end
  endtask

  task automatic check_a4(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3, input int base);
    logic [15:0] ev[4];
    int ei[4];
    ev = '{e0, e1, e2, e3};
    ei = '{5, 7, 13, 15};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= qa_d.size() || qa_d[i] !== ev[i]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %h expected %h", tag, i, (i < qa_d.size()) ? qa_d[i] : 16'hxxxx, ev[i]);
      end
      total++;
      if (i >= qa_t.size() || qa_t[i] !== acc[base + ei[i]]) begin
        bad++;
        $display("FAIL %s stamp[%0d]: got %0d expected %0d", tag, i, (i < qa_t.size()) ? qa_t[i] : -1, acc[base + ei[i]]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_data = 16'd77; i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h expected 0000", a_data); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", a_done); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    total++; if (c_busy !== 1'b0 || c_valid !== 1'b0) begin bad++; $display("FAIL reset_c: got busy=%b valid=%b expected 0 0", c_busy, c_valid); end
    do_reset();
  endtask

  task automatic test_ascending();
    do_reset();
    send(16'd1, 1'b1, 0, acc[0]);
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL asc_busy_first: got %b expected 1", a_busy); end
    for (int i = 1; i < 16; i++) send(16'(i + 1), 1'b0, 0, acc[i]);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 4) begin bad++; $display("FAIL asc_count: got %0d expected 4", qa_d.size()); end
    check_a4("asc", 16'd6, 16'd8, 16'd14, 16'd16, 0);
    total++; if (qa_done.size() != 1 || qa_done[0] !== acc[15]) begin bad++; $display("FAIL asc_done: got n=%0d expected 1 at %0d", qa_done.size(), acc[15]); end
    total++; if (qa_db.size() != 1 || qa_db[0] !== 1'b0) begin bad++; $display("FAIL asc_busy_at_done: got %0d entries expected busy 0", qa_db.size()); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL asc_busy_idle: got %b expected 0", a_busy); end
  endtask

  task automatic test_negative();
    do_reset();
    send_frame(16, 2, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 4 || qb_d.size() != 4) begin bad++; $display("FAIL neg_count: got a=%0d b=%0d expected 4 4", qa_d.size(), qb_d.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= qa_d.size() || qa_d[i] !== 16'h0000) begin bad++; $display("FAIL neg_relu[%0d]: got %h expected 0000", i, (i < qa_d.size()) ? qa_d[i] : 16'hxxxx); end
      total++;
      if (i >= qb_d.size() || qb_d[i] !== 16'hFFFD) begin bad++; $display("FAIL neg_bypass[%0d]: got %h expected fffd", i, (i < qb_d.size()) ? qb_d[i] : 16'hxxxx); end
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_frame(16, 0, 0, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 4) begin bad++; $display("FAIL gap_count: got %0d expected 4", qa_d.size()); end
    check_a4("gap", 16'd6, 16'd8, 16'd14, 16'd16, 0);
    total++; if (qa_done.size() != 1 || qa_done[0] !== acc[15]) begin bad++; $display("FAIL gap_done: got n=%0d expected 1 at %0d", qa_done.size(), acc[15]); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_frame(7, 0, 0, 0, 1'b1);
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b expected 1", a_busy); end
    do_reset();
    total++; if (a_busy !== 1'b0 || a_data !== 16'h0) begin bad++; $display("FAIL rstmid_after: got busy=%b data=%h expected 0 0000", a_busy, a_data); end
    send_frame(16, 1, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 4) begin bad++; $display("FAIL rstmid_count: got %0d expected 4", qa_d.size()); end
    check_a4("rstmid", 16'd16, 16'd14, 16'd8, 16'd6, 0);
    total++; if (qa_done.size() != 1 || qa_done[0] !== acc[15]) begin bad++; $display("FAIL rstmid_done: got n=%0d expected 1 at %0d", qa_done.size(), acc[15]); end
  endtask

  task automatic test_mid_start();
    do_reset();
    send_frame(5, 0, 0, 0, 1'b1);
    send_frame(16, 0, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 4) begin bad++; $display("FAIL midstart_count: got %0d expected 4", qa_d.size()); end
    check_a4("midstart", 16'd6, 16'd8, 16'd14, 16'd16, 0);
    total++; if (qa_done.size() != 1) begin bad++; $display("FAIL midstart_done: got %0d pulses expected 1", qa_done.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(16, 0, 0, 0, 1'b1);
    send_frame(16, 1, 16, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qa_d.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d expected 8", qa_d.size()); end
    check_a4("b2b_f0", 16'd6, 16'd8, 16'd14, 16'd16, 0);
    for (int i = 0; i < 4; i++) begin
      if (qa_d.size() > 0) void'(qa_d.pop_front());
      if (qa_t.size() > 0) void'(qa_t.pop_front());
    end
    check_a4("b2b_f1", 16'd16, 16'd14, 16'd8, 16'd6, 16);
    total++; if (qa_done.size() != 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", qa_done.size()); end
    total++; if (qa_done.size() < 2 || qa_done[0] !== acc[15] || qa_done[1] !== acc[31]) begin bad++; $display("FAIL b2b_done_stamp: got n=%0d expected at %0d and %0d", qa_done.size(), acc[15], acc[31]); end
  endtask

  task automatic test_odd_map();
    logic [15:0] ev[4];
    int ei[4];
    ev = '{16'd7, 16'd9, 16'd17, 16'd19};
    ei = '{6, 8, 16, 18};
    do_reset();
    send_frame(25, 0, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (qc_d.size() != 4) begin bad++; $display("FAIL odd_count: got %0d expected 4", qc_d.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= qc_d.size() || qc_d[i] !== ev[i]) begin bad++; $display("FAIL odd_data[%0d]: got %h expected %h", i, (i < qc_d.size()) ? qc_d[i] : 16'hxxxx, ev[i]); end
      total++;
      if (i >= qc_t.size() || qc_t[i] !== acc[ei[i]]) begin bad++; $display("FAIL odd_stamp[%0d]: got %0d expected %0d", i, (i < qc_t.size()) ? qc_t[i] : -1, acc[ei[i]]); end
    end
    total++; if (qc_done.size() != 1 || qc_done[0] !== acc[24]) begin bad++; $display("FAIL odd_done: got n=%0d expected 1 at %0d", qc_done.size(), acc[24]); end
    total++; if (c_busy !== 1'b0) begin bad++; $display("FAIL odd_busy: got %b expected 0", c_busy); end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_negative();
    test_gaps();
    test_rst_mid();
    test_mid_start();
    test_back_to_back();
    test_odd_map();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
